// File: rtl/alu_seq.sv
// alu_seq: registered ALU (logic, shift/rotate, arithmetic, compare) with persistent status flags and valid/ready handshakes.
// Define ALU_SEQ_BARREL_EN for single-cycle shifts; otherwise shifts move one bit position per cycle.
module alu_seq #(
  parameter int WORD_WIDTH = 20,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [3:0]             op,
  input  logic                   mode,
  input  logic [WORD_WIDTH-1:0]  a,
  input  logic [WORD_WIDTH-1:0]  b,
  input  logic [SHAMT_WIDTH-1:0] shamt,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WORD_WIDTH-1:0]  result,
  output logic                   zero,
  output logic                   sign,
  output logic                   carry,
  output logic                   overflow
);
  localparam int H = WORD_WIDTH / 2;
  localparam logic [WORD_WIDTH-1:0] HMASK = {{(WORD_WIDTH-H){1'b0}}, {H{1'b1}}};
  localparam logic [WORD_WIDTH-1:0] ONE = {{(WORD_WIDTH-1){1'b0}}, 1'b1};
`ifdef ALU_SEQ_BARREL_EN
  localparam bit ITER = 1'b0;
`else
  localparam bit ITER = 1'b1;
`endif
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t state, state_n;
  logic [WORD_WIDTH-1:0] mask, am, bm, bo, ar, res_c, work;
  logic [WORD_WIDTH:0] sum, diff, sh, nxt;
  logic [SHAMT_WIDTH-1:0] cnt;
  logic [1:0] op_r;
  logic mode_r, sub, ci, cmp, z_c, s_c, c_c, v_c, go_exec;

  function automatic logic top(input logic [WORD_WIDTH-1:0] x, input logic m);
    return m ? x[WORD_WIDTH-1] : x[H-1];
  endfunction

  // one bit position of SHL/SHR/ROTL/ROTR at the active width; MSB of the return is the bit moved out
  function automatic logic [WORD_WIDTH:0] step(input logic [1:0] o, input logic m, input logic [WORD_WIDTH-1:0] w);
    logic c;
    logic [WORD_WIDTH-1:0] msk, tb, r;
    c = o[0] ? w[0] : top(w, m);
    msk = m ? '1 : HMASK;
    tb = m ? ONE << (WORD_WIDTH-1) : ONE << (H-1);
    r = (o[0] ? w >> 1 : (w << 1) & msk) | ((o[1] & c) ? (o[0] ? tb : ONE) : '0);
    return {c, r};
  endfunction

  always_comb begin
    mask = mode ? '1 : HMASK;
    am = a & mask;
    bm = b & mask;
    bo = (op == 4'd8 || op == 4'd9) ? ONE : bm;
    ci = (op == 4'd11 || op == 4'd13) & carry;
    sub = op == 4'd9 || op == 4'd12 || op == 4'd13;
    cmp = op[3:1] == 3'd7;
    sum = {1'b0, am} + {1'b0, bo} + {{WORD_WIDTH{1'b0}}, ci};
    diff = {1'b0, am} - {1'b0, bo} - {{WORD_WIDTH{1'b0}}, ci};
    ar = (sub ? diff[WORD_WIDTH-1:0] : sum[WORD_WIDTH-1:0]) & mask;
    sh = {carry, am};
`ifdef ALU_SEQ_BARREL_EN
    for (int i = 0; i < 2**SHAMT_WIDTH - 1; i++)
      sh = (i < int'(shamt)) ? step(op[1:0], mode, sh[WORD_WIDTH-1:0]) : sh;
`endif
    res_c = op[3:2] == 2'd0 ? (op[1] ? (op[0] ? am ^ bm : am | bm) : (op[0] ? am & bm : ~am & mask))
          : op[3:2] == 2'd1 ? sh[WORD_WIDTH-1:0]
          : cmp ? {{(WORD_WIDTH-1){1'b0}}, op[0] ? am < bm : am == bm} : ar;
    z_c = cmp ? am == bm : res_c == '0;
    s_c = cmp ? am < bm : top(res_c, mode);
    c_c = op[3:2] == 2'd0 ? 1'b0 : op[3:2] == 2'd1 ? sh[WORD_WIDTH] : cmp ? carry
        : sub ? diff[WORD_WIDTH] : (mode ? sum[WORD_WIDTH] : sum[H]);
    v_c = op[3] & ~cmp & (sub ? top(am, mode) != top(bo, mode) : top(am, mode) == top(bo, mode))
        & (top(ar, mode) != top(am, mode));
    go_exec = ITER && op[3:2] == 2'd1 && shamt != '0;
    nxt = step(op_r, mode_r, work);
    state_n = state == IDLE ? (in_valid ? (go_exec ? EXEC : DONE) : IDLE)
            : state == EXEC ? (cnt == SHAMT_WIDTH'(1) ? DONE : EXEC)
            : (out_ready ? IDLE : DONE);
  end

  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      result <= '0;
      {zero, sign, carry, overflow} <= '0;
      work <= '0;
      cnt <= '0;
      op_r <= '0;
      mode_r <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && in_valid && go_exec) begin
        work <= am;
        cnt <= shamt;
        op_r <= op[1:0];
        mode_r <= mode;
      end else if (state == IDLE && in_valid) begin
        result <= res_c;
        {zero, sign, carry, overflow} <= {z_c, s_c, c_c, v_c};
      end else if (state == EXEC) begin
        work <= nxt[WORD_WIDTH-1:0];
        cnt <= cnt - 1'b1;
        if (cnt == SHAMT_WIDTH'(1)) begin
          result <= nxt[WORD_WIDTH-1:0];
          {zero, sign, carry, overflow} <= {nxt[WORD_WIDTH-1:0] == '0, top(nxt[WORD_WIDTH-1:0], mode_r), nxt[WORD_WIDTH], 1'b0};
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed table, handshake/reset sequences and random ops against a reference model for alu_seq.
module tb_alu_seq;
  localparam int WW = 20;
  localparam int SW = 5;
`ifdef ALU_SEQ_BARREL_EN
  localparam bit BAR = 1'b1;
`else
  localparam bit BAR = 1'b0;
`endif
  typedef struct {logic [WW-1:0] r; logic z, s, c, v;} res_t;
  typedef struct {logic [3:0] o; logic md; logic [WW-1:0] x, y; logic [SW-1:0] s; res_t e;} vec_t;

  logic clk = 0, rst = 1, in_valid = 0, mode = 0, out_ready = 0;
  logic in_ready, out_valid, zero, sign, carry, overflow;
  logic [3:0] op = 0;
  logic [WW-1:0] a = 0, b = 0, result;
  logic [SW-1:0] shamt = 0;
  int n_cmp = 0, n_bad = 0;
  logic mc = 0;

  always #5 clk = ~clk;

  alu_seq #(.WORD_WIDTH(WW), .SHAMT_WIDTH(SW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .mode(mode),
    .a(a), .b(b), .shamt(shamt), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .sign(sign), .carry(carry), .overflow(overflow)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cmp_res(input string nm, input res_t act, input res_t exp);
    chk({nm, " result"}, act.r, exp.r);
    chk({nm, " zero"}, act.z, exp.z);
    chk({nm, " sign"}, act.s, exp.s);
    chk({nm, " carry"}, act.c, exp.c);
    chk({nm, " overflow"}, act.v, exp.v);
  endtask

  // arithmetic view of each op at width w, independent of any bit-serial mechanism
  function automatic res_t model(input logic [3:0] o, input logic md, input logic [WW-1:0] x, input logic [WW-1:0] y,
                                 input logic [SW-1:0] sh, input logic cin);
    longint w, m, aa, bb, t, n, k, sa, sb, st;
    res_t q;
    w = md ? WW : WW / 2;
    m = (64'd1 << w) - 1;
    aa = longint'(x) & m;
    bb = longint'(y) & m;
    n = longint'(sh);
    k = n % w;
    sa = aa >= (m + 1) / 2 ? aa - (m + 1) : aa;
    sb = bb >= (m + 1) / 2 ? bb - (m + 1) : bb;
    st = 0;
    t = 0;
    q.c = 0;
    q.v = 0;
    case (o)
      0: t = ~aa & m;
      1: t = aa & bb;
      2: t = aa | bb;
      3: t = aa ^ bb;
      4: begin t = (aa << n) & m; q.c = n == 0 ? cin : (n <= w ? aa[w-n] : 1'b0); end
      5: begin t = aa >> n; q.c = n == 0 ? cin : (n <= w ? aa[n-1] : 1'b0); end
      6: begin t = ((aa << k) | (aa >> (w - k))) & m; q.c = n == 0 ? cin : t[0]; end
      7: begin t = ((aa >> k) | (aa << (w - k))) & m; q.c = n == 0 ? cin : t[w-1]; end
      8: begin t = aa + 1; st = sa + 1; end
      9: begin t = aa - 1; st = sa - 1; end
      10: begin t = aa + bb; st = sa + sb; end
      11: begin t = aa + bb + longint'(cin); st = sa + sb + longint'(cin); end
      12: begin t = aa - bb; st = sa - sb; end
      13: begin t = aa - bb - longint'(cin); st = sa - sb - longint'(cin); end
      default: t = (o == 14) ? longint'(aa == bb) : longint'(aa < bb);
    endcase
    if (o >= 8 && o <= 13) begin
      q.c = (o == 8 || o == 10 || o == 11) ? t > m : t < 0;
      q.v = st > m / 2 || st < -((m + 1) / 2);
      t = t & m;
    end
    q.r = WW'(t);
    q.z = t == 0;
    q.s = t[w-1];
    if (o >= 14) begin
      q.z = aa == bb;
      q.s = aa < bb;
      q.c = cin;
    end
    return q;
  endfunction

  task automatic run_op(input logic [3:0] o, input logic md, input logic [WW-1:0] x, input logic [WW-1:0] y,
                        input logic [SW-1:0] s, output res_t q);
    int lat = 0;
    @(negedge clk);
    chk("in_ready before op", in_ready, 1);
    op = o; mode = md; a = x; b = y; shamt = s; in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
    a = $urandom; b = $urandom; op = 4'($urandom); shamt = SW'($urandom); mode = 1'($urandom);
    do begin @(negedge clk); lat++; end while (!out_valid && lat < 100);
    chk("latency", lat, (!BAR && o[3:2] == 2'd1 && s != 0) ? 1 + int'(s) : 1);
    q.r = result; q.z = zero; q.s = sign; q.c = carry; q.v = overflow;
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      chk("held result", result, q.r);
      chk("held out_valid", out_valid, 1);
    end
    out_ready = 1;
    @(posedge clk);
    #1 out_ready = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl[15];
    res_t q, e;
    tbl[0]  = '{4'd10, 1'b1, 20'hFFFFF, 20'h00001, 5'd0,  '{20'h00000, 1'b1, 1'b0, 1'b1, 1'b0}};
    tbl[1]  = '{4'd11, 1'b1, 20'h00000, 20'h00000, 5'd0,  '{20'h00001, 1'b0, 1'b0, 1'b0, 1'b0}};
    tbl[2]  = '{4'd12, 1'b0, 20'hABC05, 20'h00006, 5'd0,  '{20'h003FF, 1'b0, 1'b1, 1'b1, 1'b0}};
    tbl[3]  = '{4'd4,  1'b1, 20'h80001, 20'h00000, 5'd3,  '{20'h00008, 1'b0, 1'b0, 1'b0, 1'b0}};
    tbl[4]  = '{4'd7,  1'b0, 20'h00001, 20'h00000, 5'd1,  '{20'h00200, 1'b0, 1'b1, 1'b1, 1'b0}};
    tbl[5]  = '{4'd14, 1'b1, 20'h12345, 20'h12345, 5'd0,  '{20'h00001, 1'b1, 1'b0, 1'b1, 1'b0}};
    tbl[6]  = '{4'd13, 1'b1, 20'h00005, 20'h00002, 5'd0,  '{20'h00002, 1'b0, 1'b0, 1'b0, 1'b0}};
    tbl[7]  = '{4'd10, 1'b1, 20'h7FFFF, 20'h00001, 5'd0,  '{20'h80000, 1'b0, 1'b1, 1'b0, 1'b1}};
    tbl[8]  = '{4'd5,  1'b1, 20'h80000, 20'h00000, 5'd19, '{20'h00001, 1'b0, 1'b0, 1'b0, 1'b0}};
    tbl[9]  = '{4'd15, 1'b1, 20'h00003, 20'h00005, 5'd0,  '{20'h00001, 1'b0, 1'b1, 1'b0, 1'b0}};
    tbl[10] = '{4'd6,  1'b0, 20'h00201, 20'h00000, 5'd10, '{20'h00201, 1'b0, 1'b1, 1'b1, 1'b0}};
    tbl[11] = '{4'd4,  1'b1, 20'hFFFFF, 20'h00000, 5'd25, '{20'h00000, 1'b1, 1'b0, 1'b0, 1'b0}};
    tbl[12] = '{4'd9,  1'b0, 20'h00000, 20'h00000, 5'd0,  '{20'h003FF, 1'b0, 1'b1, 1'b1, 1'b0}};
    tbl[13] = '{4'd0,  1'b0, 20'hFF3FF, 20'h00000, 5'd0,  '{20'h00000, 1'b1, 1'b0, 1'b0, 1'b0}};
    tbl[14] = '{4'd5,  1'b1, 20'h80000, 20'h00000, 5'd20, '{20'h00000, 1'b1, 1'b0, 1'b1, 1'b0}};

    repeat (2) @(negedge clk);
    chk("reset in_ready", in_ready, 1);
    chk("reset out_valid", out_valid, 0);
    chk("reset result", result, 0);
    chk("reset flags", {zero, sign, carry, overflow}, 0);
    rst = 0;
    repeat (2) @(negedge clk);
    chk("idle in_ready", in_ready, 1);
    chk("idle out_valid", out_valid, 0);

    for (int i = 0; i < 15; i++) begin
      run_op(tbl[i].o, tbl[i].md, tbl[i].x, tbl[i].y, tbl[i].s, q);
      cmp_res($sformatf("vec%0d", i), q, tbl[i].e);
      mc = tbl[i].e.c;
    end

    // backpressure: AND result held while a competing request waits
    @(negedge clk);
    op = 4'd1; mode = 1; a = 20'hF0F0F; b = 20'h0FF0F; shamt = 0; in_valid = 1;
    @(posedge clk);
    #1 op = 4'd10; a = 1; b = 1;
    @(negedge clk);
    chk("bp out_valid", out_valid, 1);
    chk("bp result", result, 20'h00F0F);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp hold out_valid", out_valid, 1);
      chk("bp hold in_ready", in_ready, 0);
      chk("bp hold result", result, 20'h00F0F);
      chk("bp hold flags", {zero, sign, carry, overflow}, 0);
    end
    in_valid = 0;
    out_ready = 1;
    @(posedge clk);
    #1 out_ready = 0;
    @(negedge clk);
    chk("bp release in_ready", in_ready, 1);
    chk("bp release out_valid", out_valid, 0);
    @(negedge clk);
    chk("bp no stale accept", out_valid, 0);

    // reset during DONE
    @(negedge clk);
    op = 4'd10; mode = 1; a = 20'hFFFFF; b = 20'h00001; in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
    @(negedge clk);
    chk("done before rst", {out_valid, zero, carry}, 3'b111);
    rst = 1;
    #1;
    chk("rst done out_valid", out_valid, 0);
    chk("rst done in_ready", in_ready, 1);
    chk("rst done flags", {zero, sign, carry, overflow}, 0);
    @(negedge clk);
    rst = 0;

    // reset during EXEC of SHL by 7 (already DONE with the barrel shifter)
    @(negedge clk);
    op = 4'd4; mode = 1; a = 20'h12345; b = 0; shamt = 5'd7; in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
    repeat (3) @(negedge clk);
    chk("mid shl out_valid", out_valid, BAR ? 1 : 0);
    rst = 1;
    #1;
    chk("rst shl out_valid", out_valid, 0);
    chk("rst shl result", result, 0);
    chk("rst shl flags", {zero, sign, carry, overflow}, 0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("post rst in_ready", in_ready, 1);
    repeat (8) @(negedge clk);
    chk("post rst discarded", out_valid, 0);
    mc = 0;

    for (int i = 0; i < 150; i++) begin
      logic [3:0] o;
      logic md;
      logic [WW-1:0] x, y;
      logic [SW-1:0] s;
      o = 4'($urandom); md = 1'($urandom); x = WW'($urandom); y = WW'($urandom);
      s = ($urandom_range(0, 3) == 0) ? SW'($urandom_range(0, 2)) : SW'($urandom);
      if (o >= 14 && $urandom_range(0, 2) == 0) y = x;
      e = model(o, md, x, y, s, mc);
      run_op(o, md, x, y, s, q);
      cmp_res($sformatf("rnd%0d op%0d", i, o), q, e);
      mc = e.c;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
